// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60 timing generator with sync, pixel coordinates and frame/line strobes
// Every output register is loaded from the next-counter value, so outputs describe the counter state loaded on the same edge.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        line_end,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       video_nxt;
  logic       origin_nxt;
  logic       line_end_nxt;

  // The >= compares make any out-of-range value fall straight back into the legal range.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (en) begin
      if (h_cnt >= H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt >= V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  // With en low the next counters equal the current ones, so sync/video/pixel simply hold.
  always_comb begin
    hsync_nxt    = ((h_nxt >= H_SYNC_FIRST) && (h_nxt <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt    = ((v_nxt >= V_SYNC_FIRST) && (v_nxt <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_nxt    = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    origin_nxt   = en && (h_nxt == '0) && (v_nxt == '0);
    line_end_nxt = en && (h_nxt == H_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      video_on    <= video_nxt;
      pixel_x     <= video_nxt ? h_nxt : '0;
      pixel_y     <= video_nxt ? v_nxt : '0;
      frame_start <= origin_nxt;
      line_end    <= line_end_nxt;
      if (origin_nxt) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
// Instance a uses the 640x480 timing, instance b a reduced timing with active-high sync so whole frames fit a short run.
module tb_vga_sync_gen;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48, AVA = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AFR = AHT * (AVA + AVF + AVS + AVB);
  localparam int BHA = 40, BHF = 4, BHS = 8, BHB = 6, BVA = 30, BVF = 3, BVS = 2, BVB = 5;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BFR = BHT * (BVA + BVF + BVS + BVB);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vo;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        fs;
    logic        le;
    logic [15:0] fc;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic hsync_a, vsync_a, video_on_a, frame_start_a, line_end_a;
  logic [9:0] pixel_x_a, pixel_y_a;
  logic [15:0] frame_cnt_a;
  logic hsync_b, vsync_b, video_on_b, frame_start_b, line_end_b;
  logic [9:0] pixel_x_b, pixel_y_b;
  logic [15:0] frame_cnt_b;

  outs_t oa, ob;
  assign oa = {hsync_a, vsync_a, video_on_a, pixel_x_a, pixel_y_a, frame_start_a, line_end_a, frame_cnt_a};
  assign ob = {hsync_b, vsync_b, video_on_b, pixel_x_b, pixel_y_b, frame_start_b, line_end_b, frame_cnt_b};

  vga_sync_gen u_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .frame_start(frame_start_a), .line_end(line_end_a), .frame_cnt(frame_cnt_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .frame_start(frame_start_b), .line_end(line_end_b), .frame_cnt(frame_cnt_b)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Model state: linear position within the frame, frames started, and whether the last edge was enabled.
  int pa, pb, fca, fcb;
  bit act;

  function automatic outs_t model(int p, int fc, bit a, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, bit pol);
    outs_t o;
    int ht, h, v;
    ht = ha + hf + hs + hb;
    h = p % ht;
    v = p / ht;
    o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    o.vs = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    o.vo = (h < ha) && (v < va);
    o.px = o.vo ? 10'(h) : 10'd0;
    o.py = o.vo ? 10'(v) : 10'd0;
    o.fs = a && (p == 0);
    o.le = a && (h == ht - 1);
    o.fc = 16'(fc);
    return o;
  endfunction

  function automatic outs_t exp_a();
    return model(pa, fca, act, AHA, AHF, AHS, AHB, AVA, AVF, AVS, 1'b0);
  endfunction

  function automatic outs_t exp_b();
    return model(pb, fcb, act, BHA, BHF, BHS, BHB, BVA, BVF, BVS, 1'b1);
  endfunction

  task automatic model_reset();
    pa = AFR - 1;
    pb = BFR - 1;
    fca = 0;
    fcb = 0;
    act = 1'b0;
  endtask

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    if (e) begin
      pa = (pa + 1) % AFR;
      pb = (pb + 1) % BFR;
      if (pa == 0) fca = (fca + 1) % 65536;
      if (pb == 0) fcb = (fcb + 1) % 65536;
    end
    act = e;
    #1;
  endtask

  task automatic test_reset();
    outs_t ra, rb;
    ra = '{hs: 1'b1, vs: 1'b1, vo: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0, le: 1'b0, fc: 16'd0};
    rb = '{hs: 1'b0, vs: 1'b0, vo: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0, le: 1'b0, fc: 16'd0};
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (oa !== ra) begin errors++; $display("FAIL reset_a got %h exp %h", oa, ra); end
    checks++;
    if (ob !== rb) begin errors++; $display("FAIL reset_b got %h exp %h", ob, rb); end
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (oa !== ra) begin errors++; $display("FAIL reset_hold_a got %h exp %h", oa, ra); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_edge(input string tag);
    tick(1'b1);
    checks++;
    if (frame_start_a !== 1'b1) begin errors++; $display("FAIL %s_frame_start got %b exp 1", tag, frame_start_a); end
    checks++;
    if (video_on_a !== 1'b1) begin errors++; $display("FAIL %s_video_on got %b exp 1", tag, video_on_a); end
    checks++;
    if (pixel_x_a !== 10'd0 || pixel_y_a !== 10'd0) begin
      errors++; $display("FAIL %s_pixel got (%0d,%0d) exp (0,0)", tag, pixel_x_a, pixel_y_a);
    end
    checks++;
    if (frame_cnt_a !== 16'd1) begin errors++; $display("FAIL %s_frame_cnt got %0d exp 1", tag, frame_cnt_a); end
    checks++;
    if (ob !== exp_b()) begin errors++; $display("FAIL %s_b got %h exp %h", tag, ob, exp_b()); end
  endtask

  task automatic test_line();
    int n_vo = 0, n_hs = 0, hs_first = -1, hs_last = -1, n_le = 0, le_h = -1, bad = 0, h;
    for (int i = 0; i < AHT; i++) begin
      h = pa % AHT;
      if (video_on_a) n_vo++;
      if (hsync_a === 1'b0) begin
        n_hs++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (line_end_a) begin n_le++; le_h = h; end
      if (oa !== exp_a()) bad++;
      if (i < AHT - 1) tick(1'b1);
    end
    checks++;
    if (n_vo != 640) begin errors++; $display("FAIL line_video_clks got %0d exp 640", n_vo); end
    checks++;
    if (n_hs != 96) begin errors++; $display("FAIL line_hsync_clks got %0d exp 96", n_hs); end
    checks++;
    if (hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL line_hsync_span got %0d..%0d exp 656..751", hs_first, hs_last);
    end
    checks++;
    if (n_le != 1 || le_h != 799) begin
      errors++; $display("FAIL line_end got %0d pulses at h=%0d exp 1 at h=799", n_le, le_h);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL line_track got %0d bad clks exp 0", bad); end
    tick(1'b1);
    checks++;
    if (line_end_a !== 1'b0 || pixel_x_a !== 10'd0 || pixel_y_a !== 10'd1 || video_on_a !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap got le=%b px=%0d py=%0d vo=%b exp le=0 px=0 py=1 vo=1",
               line_end_a, pixel_x_a, pixel_y_a, video_on_a);
    end
  endtask

  task automatic test_pixel_bounds();
    int n = 0;
    while (pb != 29 * BHT + 39 && n < 2 * BFR) begin tick(1'b1); n++; end
    checks++;
    if (pixel_x_b !== 10'd39 || pixel_y_b !== 10'd29 || video_on_b !== 1'b1) begin
      errors++;
      $display("FAIL pixel_last got (%0d,%0d) vo=%b exp (39,29) vo=1", pixel_x_b, pixel_y_b, video_on_b);
    end
    tick(1'b1);
    checks++;
    if (pixel_x_b !== 10'd0 || pixel_y_b !== 10'd0 || video_on_b !== 1'b0) begin
      errors++;
      $display("FAIL pixel_blank got (%0d,%0d) vo=%b exp (0,0) vo=0", pixel_x_b, pixel_y_b, video_on_b);
    end
  endtask

  task automatic test_frame();
    int n = 0, n_vs = 0, n_vo = 0, bad_vo = 0;
    logic [15:0] fc0;
    while (frame_start_b !== 1'b1 && n < 2 * BFR) begin tick(1'b1); n++; end
    checks++;
    if (frame_start_b !== 1'b1) begin errors++; $display("FAIL frame_sync timeout got 0 exp frame_start"); end
    fc0 = frame_cnt_b;
    n = 0;
    do begin
      tick(1'b1);
      n++;
      if (vsync_b === 1'b1) n_vs++;
      if (video_on_b) n_vo++;
      if (video_on_b && (pb / BHT) >= BVA) bad_vo++;
    end while (frame_start_b !== 1'b1 && n < 2 * BFR);
    checks++;
    if (n != BFR) begin errors++; $display("FAIL frame_period got %0d exp %0d", n, BFR); end
    checks++;
    if (n_vs != BVS * BHT) begin errors++; $display("FAIL frame_vsync_clks got %0d exp %0d", n_vs, BVS * BHT); end
    checks++;
    if (n_vo != BHA * BVA || bad_vo != 0) begin
      errors++; $display("FAIL frame_video got %0d clks (%0d blank-line) exp %0d (0)", n_vo, bad_vo, BHA * BVA);
    end
    checks++;
    if (frame_cnt_b !== 16'(fc0 + 16'd1)) begin
      errors++; $display("FAIL frame_cnt_inc got %0d exp %0d", frame_cnt_b, fc0 + 16'd1);
    end
  endtask

  task automatic test_enable_hold();
    outs_t ha, hb;
    int bad = 0, n = 0, cnt = 0;
    bit e;
    repeat ($urandom_range(200, 500)) tick(1'b1);
    ha = oa; ha.fs = 1'b0; ha.le = 1'b0;
    hb = ob; hb.fs = 1'b0; hb.le = 1'b0;
    repeat (100) begin
      tick(1'b0);
      if (oa !== ha || ob !== hb) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_frozen got %0d bad clks exp 0", bad); end
    tick(1'b1);
    checks++;
    if (oa !== exp_a() || ob !== exp_b()) begin
      errors++; $display("FAIL hold_resume got %h/%h exp %h/%h", oa, ob, exp_a(), exp_b());
    end
    while (line_end_a !== 1'b1 && n < 2 * AHT) begin tick(1'b1); n++; end
    tick(1'b0);
    checks++;
    if (line_end_a !== 1'b0 || oa !== exp_a()) begin
      errors++; $display("FAIL hold_no_stretch got %h exp %h", oa, exp_a());
    end
    n = 0;
    while (frame_start_b !== 1'b1 && n < 3 * BFR) begin tick(1'b1); n++; end
    n = 0;
    do begin
      e = ($urandom_range(0, 3) != 0);
      tick(e);
      if (e) cnt++;
      n++;
    end while (frame_start_b !== 1'b1 && n < 8 * BFR);
    checks++;
    if (cnt != BFR) begin errors++; $display("FAIL hold_enabled_period got %0d exp %0d", cnt, BFR); end
  endtask

  task automatic test_random();
    int bad_a = 0, bad_b = 0;
    for (int i = 0; i < 8000; i++) begin
      tick($urandom_range(0, 3) != 0);
      if (oa !== exp_a()) bad_a++;
      if (ob !== exp_b()) bad_b++;
    end
    checks++;
    if (bad_a != 0) begin errors++; $display("FAIL random_a got %0d bad clks exp 0", bad_a); end
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL random_b got %0d bad clks exp 0", bad_b); end
  endtask

  task automatic test_reset_in_vsync();
    int n = 0;
    while (vsync_b !== 1'b1 && n < 2 * BFR) begin tick(1'b1); n++; end
    checks++;
    if (vsync_b !== 1'b1) begin errors++; $display("FAIL rst_vsync_reach timeout got 0 exp 1"); end
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (vsync_b !== 1'b0 || hsync_b !== 1'b0 || frame_cnt_b !== 16'd0) begin
      errors++;
      $display("FAIL rst_async_b got vs=%b hs=%b fc=%0d exp vs=0 hs=0 fc=0", vsync_b, hsync_b, frame_cnt_b);
    end
    checks++;
    if (vsync_a !== 1'b1 || hsync_a !== 1'b1 || frame_cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL rst_async_a got vs=%b hs=%b fc=%0d exp vs=1 hs=1 fc=0", vsync_a, hsync_a, frame_cnt_a);
    end
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_first_edge("rerun");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_edge("first");
    test_line();
    test_pixel_bounds();
    test_frame();
    test_enable_hold();
    test_random();
    test_reset_in_vsync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
